// File: rtl/program_loader.sv
// rtl/program_loader.sv - length/payload/checksum byte-stream loader that writes a RAM image and holds the CPU.
// Registered outputs are recomputed from the next state so they change on the same edge as the FSM.
module program_loader (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] ram_data,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] byte_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] xor_q, xor_d;
  logic [7:0] len_q, len_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic       ram_we_q, ram_we_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       cpu_hold_q, cpu_hold_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    xor_d      = xor_q;
    len_d      = len_q;
    ram_we_d   = 1'b0;
    ram_data_d = ram_data_q;
    ram_addr_d = ram_addr_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
          count_d = 8'd0;
          xor_d   = 8'd0;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          len_d   = in_data;
          state_d = (in_data == 8'd0) ? ST_ERR : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          // The byte count doubles as the write pointer: addresses run 0..L-1.
          ram_we_d   = 1'b1;
          ram_data_d = in_data;
          ram_addr_d = count_q;
          count_d    = count_q + 8'd1;
          xor_d      = xor_q ^ in_data;
          if (count_q + 8'd1 == len_q) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (xfer) begin
          state_d = (in_data == xor_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LEN) || (state_d == ST_LOAD) || (state_d == ST_CHK);
    busy_d     = in_ready_d;
    cpu_hold_d = in_ready_d || (state_d == ST_ERR);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= 8'd0;
      xor_q      <= 8'd0;
      len_q      <= 8'd0;
      ram_we_q   <= 1'b0;
      ram_data_q <= 8'd0;
      ram_addr_q <= 8'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      xor_q      <= xor_d;
      len_q      <= len_d;
      ram_we_q   <= ram_we_d;
      ram_data_q <= ram_data_d;
      ram_addr_q <= ram_addr_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign ram_data   = ram_data_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed bench for program_loader with a RAM-write scoreboard.
module tb_program_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ram_data;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] byte_count;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  program_loader dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_data   (ram_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the oldest outstanding expected (addr,data).
  always @(negedge clock) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 8'd1, 8'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("ram_addr", ram_addr, e[15:8]);
        check("ram_data", ram_data, e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 8'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] addr, input logic [7:0] b);
    exp_q.push_back({addr, b});
    send(b);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 8'd0);
    check({tag, "_ram_we"}, ram_we, 8'd0);
    check({tag, "_ram_data"}, ram_data, 8'd0);
    check({tag, "_ram_addr"}, ram_addr, 8'd0);
    check({tag, "_busy"}, busy, 8'd0);
    check({tag, "_done"}, done, 8'd0);
    check({tag, "_error"}, error, 8'd0);
    check({tag, "_byte_count"}, byte_count, 8'd0);
    check({tag, "_cpu_hold"}, cpu_hold, 8'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    check_reset_vals("rst");

    // Good frame, back-to-back.
    pulse_start();
    check("len_busy", busy, 8'd1);
    check("len_hold", cpu_hold, 8'd1);
    send(8'h03);
    send_payload(8'd0, 8'hA1);
    send_payload(8'd1, 8'hB2);
    send_payload(8'd2, 8'hC3);
    send(8'hD0);
    check("s1_done", done, 8'd1);
    check("s1_error", error, 8'd0);
    check("s1_hold", cpu_hold, 8'd0);
    check("s1_busy", busy, 8'd0);
    check("s1_count", byte_count, 8'd3);
    tick();
    check("s1_we_idle", ram_we, 8'd0);
    check("s1_pending", 8'(exp_q.size()), 8'd0);

    // in_valid ignored in DONE.
    in_valid = 1'b1; in_data = 8'h55;
    tick(); tick();
    in_valid = 1'b0;
    check("done_ignore_valid", done, 8'd1);
    check("done_ignore_count", byte_count, 8'd3);

    // Bad checksum.
    pulse_start();
    check("s2_done_clr", done, 8'd0);
    check("s2_count_clr", byte_count, 8'd0);
    send(8'h03);
    send_payload(8'd0, 8'hA1);
    send_payload(8'd1, 8'hB2);
    send_payload(8'd2, 8'hC3);
    send(8'h00);
    check("s2_error", error, 8'd1);
    check("s2_done", done, 8'd0);
    check("s2_hold", cpu_hold, 8'd1);
    tick();
    check("s2_pending", 8'(exp_q.size()), 8'd0);

    // Zero length.
    pulse_start();
    check("s3_err_clr", error, 8'd0);
    send(8'h00);
    check("s3_error", error, 8'd1);
    check("s3_ready", in_ready, 8'd0);
    in_valid = 1'b1; in_data = 8'h77;
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("s3_count", byte_count, 8'd0);

    // Gapped payload.
    pulse_start();
    send(8'h02);
    send_payload(8'd0, 8'h11);
    tick();
    check("s4_stall_count", byte_count, 8'd1);
    check("s4_stall_ready", in_ready, 8'd1);
    send_payload(8'd1, 8'h22);
    tick();
    check("s4_stall2_busy", busy, 8'd1);
    send(8'h33);
    check("s4_done", done, 8'd1);
    check("s4_count", byte_count, 8'd2);
    tick();
    check("s4_pending", 8'(exp_q.size()), 8'd0);

    // Reset mid-load.
    pulse_start();
    send(8'h05);
    send_payload(8'd0, 8'h01);
    send_payload(8'd1, 8'h02);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    tick();
    reset = 1'b0;
    check_reset_vals("mid");
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("mid_idle_ready", in_ready, 8'd0);
    check("mid_pending", 8'(exp_q.size()), 8'd0);

    // start during LOAD is ignored, then restart from DONE.
    pulse_start();
    send(8'h03);
    send_payload(8'd0, 8'h44);
    start = 1'b1;
    send_payload(8'd1, 8'h55);
    start = 1'b0;
    send_payload(8'd2, 8'h66);
    send(8'h77);
    check("s6_done", done, 8'd1);
    check("s6_count", byte_count, 8'd3);
    tick();
    pulse_start();
    check("s6_restart_busy", busy, 8'd1);
    check("s6_restart_done", done, 8'd0);
    check("s6_restart_count", byte_count, 8'd0);
    check("s6_pending", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE, DONE or ERR.
- in_valid  input  1  byte stream valid.
- in_data  input  8  byte stream data.
- in_ready  output  1  loader accepts in_data this cycle.
- ram_data  output  8  RAM write data.
- ram_addr  output  8  RAM write address.
- ram_we  output  1  RAM write enable, one-cycle pulse per byte.
- cpu_hold  output  1  holds the CPU in reset while a load is in progress or has failed.
- busy  output  1  high in LEN, LOAD and CHK.
- done  output  1  load completed with a good checksum; sticky until start or reset.
- error  output  1  load failed; sticky until start or reset.
- byte_count  output  8  payload bytes written so far.

Function
REQ-003 A byte SHALL transfer on a rising edge where in_valid and in_ready are both high; in_ready SHALL be high exactly in LEN, LOAD and CHK.
REQ-004 Frame format SHALL be: a length byte L, then L payload bytes, then a checksum byte equal to the XOR of all payload bytes.
REQ-005 The FSM SHALL have the states IDLE, LEN, LOAD, CHK, DONE and ERR.
REQ-006 Transitions:
- IDLE/DONE/ERR -> LEN on start.
- LEN -> LOAD on transfer with L != 0.
- LEN -> ERR on transfer with L == 0.
- LOAD -> CHK on the transfer of payload byte L.
- CHK -> DONE on transfer with checksum match.
- CHK -> ERR on transfer with checksum mismatch.
REQ-007 On start, byte_count, the running XOR and the write pointer SHALL clear to 0, and done and error SHALL clear.
REQ-008 Each payload byte accepted in LOAD SHALL produce ram_we=1 on the following cycle, with ram_data equal to that byte and ram_addr equal to the write pointer. All three outputs SHALL be registered.
REQ-009 The write pointer and byte_count SHALL increment by 1 per accepted payload byte. Addresses SHALL be 0..L-1, so there is no wrap (L≤255).
REQ-010 ram_we SHALL be 0 in every other cycle. Length and checksum bytes SHALL never be written to RAM.
REQ-011 The running XOR SHALL update with each accepted payload byte.
REQ-012 The CHK compare SHALL use the running XOR including the final payload byte, even when the checksum byte arrives on the cycle immediately after the last payload transfer.
REQ-013 in_valid low SHALL stall the FSM indefinitely, with no timeout and no state change.
REQ-014 cpu_hold SHALL be 1 in LEN, LOAD, CHK and ERR, and 0 in IDLE and DONE.
REQ-015 done SHALL be 1 only in DONE. error SHALL be 1 only in ERR.
REQ-016 start asserted while busy SHALL be ignored.
REQ-017 In IDLE, DONE and ERR, in_valid SHALL be ignored and nothing SHALL be written.
REQ-018 Back-to-back transfers SHALL be sustained at one byte per cycle, so a frame of L payload bytes takes L+2 accepting cycles plus one cycle for the last write.

Reset
REQ-019 While reset is high at a clock edge, the block SHALL go to IDLE and SHALL drive in_ready=0, ram_we=0, ram_data=0, ram_addr=0, busy=0, done=0, error=0, byte_count=0 and cpu_hold=0.
REQ-020 Reset asserted mid-load SHALL abort the load immediately; no ram_we pulse SHALL follow the reset edge, and the RAM contents already written SHALL be left as they are.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then start, then stream 03,A1,B2,C3,D0 back-to-back -> writes (0,A1),(1,B2),(2,C3); DONE; done=1; cpu_hold=0; byte_count=3.
- Same frame with checksum 00 -> three writes occur; ERR; error=1; cpu_hold=1.
- Length 00 -> ERR after one transfer; no ram_we.
- in_valid toggled every other cycle during the payload of 02,11,22,33 -> writes (0,11),(1,22); DONE; no duplicate or missing writes.
- Reset asserted after two payload bytes of a length-05 frame -> IDLE next cycle; all outputs at reset values; no further writes.
- start pulsed during LOAD -> ignored; frame completes normally. Then start in DONE -> LEN; done cleared; byte_count=0.
